// File: rtl/micro_sequencer_pkg.sv
// Shared micro-state codes, opcode constants and execute-sequence tables
// for the 8-bit CPU core. The control-word decoder uses these same names.
package micro_sequencer_pkg;

  typedef enum logic [7:0] {
    FETCH_PC   = 8'h01,
    FETCH_INST = 8'h02,
    DECODE     = 8'h03,
    ALU_EXEC   = 8'h10,
    ALU_OUT    = 8'h11,
    MOV_REG    = 8'h12,
    SET_REG    = 8'h13,
    LOAD_ADDR  = 8'h14,
    SET_MEM    = 8'h15,
    JUMP       = 8'h16,
    FETCH_SP   = 8'h20,
    STACK_REG  = 8'h21,
    INC_SP     = 8'h22,
    STORE_PC   = 8'h23,
    TMP_JUMP   = 8'h24,
    RET        = 8'h25,
    HALT       = 8'hFF
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_JCC  = 4'h6;
  localparam logic [3:0] OP_PUSH = 4'h7;
  localparam logic [3:0] OP_POP  = 4'h8;
  localparam logic [3:0] OP_CALL = 4'h9;
  localparam logic [3:0] OP_RET  = 4'hA;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // Reserved opcodes B..E behave exactly like HLT.
  function automatic logic [3:0] normOpcode(input logic [3:0] raw);
    normOpcode = (raw >= 4'hB) ? OP_HLT : raw;
  endfunction

  // Number of execute micro-states following DECODE.
  function automatic logic [2:0] execLen(input logic [3:0] opc);
    case (opc)
      OP_NOP:  execLen = 3'd0;
      OP_MOV:  execLen = 3'd1;
      OP_HLT:  execLen = 3'd1;
      OP_ALU, OP_LDI, OP_JCC, OP_PUSH: execLen = 3'd2;
      OP_LD, OP_ST, OP_POP, OP_RET:    execLen = 3'd3;
      OP_CALL: execLen = 3'd4;
      default: execLen = 3'd1;
    endcase
  endfunction

  // Execute micro-state at position idx of the opcode's sequence.
  function automatic state_e execState(input logic [3:0] opc, input logic [1:0] idx);
    case ({opc, idx})
      {OP_ALU,  2'd0}: execState = ALU_EXEC;
      {OP_ALU,  2'd1}: execState = ALU_OUT;
      {OP_MOV,  2'd0}: execState = MOV_REG;
      {OP_LDI,  2'd0}: execState = FETCH_PC;
      {OP_LDI,  2'd1}: execState = SET_REG;
      {OP_LD,   2'd0}: execState = FETCH_PC;
      {OP_LD,   2'd1}: execState = LOAD_ADDR;
      {OP_LD,   2'd2}: execState = SET_REG;
      {OP_ST,   2'd0}: execState = FETCH_PC;
      {OP_ST,   2'd1}: execState = LOAD_ADDR;
      {OP_ST,   2'd2}: execState = SET_MEM;
      {OP_JCC,  2'd0}: execState = FETCH_PC;
      {OP_JCC,  2'd1}: execState = JUMP;
      {OP_PUSH, 2'd0}: execState = FETCH_SP;
      {OP_PUSH, 2'd1}: execState = STACK_REG;
      {OP_POP,  2'd0}: execState = INC_SP;
      {OP_POP,  2'd1}: execState = FETCH_SP;
      {OP_POP,  2'd2}: execState = SET_REG;
      {OP_CALL, 2'd0}: execState = FETCH_PC;
      {OP_CALL, 2'd1}: execState = FETCH_SP;
      {OP_CALL, 2'd2}: execState = STORE_PC;
      {OP_CALL, 2'd3}: execState = TMP_JUMP;
      {OP_RET,  2'd0}: execState = INC_SP;
      {OP_RET,  2'd1}: execState = FETCH_SP;
      {OP_RET,  2'd2}: execState = RET;
      {OP_HLT,  2'd0}: execState = HALT;
      default:         execState = FETCH_PC;
    endcase
  endfunction

endpackage

// File: rtl/micro_sequencer_step_sync.sv
// step_sync: brings the asynchronous single-step button into the clock
// domain through two flops and emits a one-cycle pulse on its rising edge.
module step_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, prev_q;

  // Two-flop synchronizer followed by an edge-history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: fetch/decode/execute micro-step FSM with retire strobe
// and retired-instruction counter. Optional single-step debug mode is
// compiled in with the macro SEQ_STEP_EN.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          ir,
  input  logic                resume,
`ifdef SEQ_STEP_EN
  input  logic                run,
  input  logic                step,
`endif
  output logic [7:0]          state,
  output logic                instr_done,
  output logic [RETIRE_W-1:0] retired
);

  state_e              state_q, state_d;
  logic [3:0]          opcode_q, opcode_d;
  logic [1:0]          execIdx_q, execIdx_d;
  logic                inExec_q, inExec_d;
  logic                done_q, done_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                advance;

`ifdef SEQ_STEP_EN
  logic stepPulse;

  step_sync u_step_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (step),
    .pulse_o (stepPulse)
  );

  assign advance = run | stepPulse;
`else
  assign advance = 1'b1;
`endif

  // State register plus the per-instruction context and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH_PC;
      opcode_q  <= OP_NOP;
      execIdx_q <= 2'd0;
      inExec_q  <= 1'b0;
      done_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      execIdx_q <= execIdx_d;
      inExec_q  <= inExec_d;
      done_q    <= done_d;
      retired_q <= retired_d;
    end
  end

  // Next micro-state: common fetch/decode prefix, then the table-driven
  // execute sequence selected by the opcode latched at DECODE.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    execIdx_d = execIdx_q;
    inExec_d  = inExec_q;
    if (advance) begin
      if (state_q == HALT) begin
        if (resume) begin
          state_d  = FETCH_PC;
          inExec_d = 1'b0;
        end
      end else if (!inExec_q) begin
        case (state_q)
          FETCH_PC:   state_d = FETCH_INST;
          FETCH_INST: state_d = DECODE;
          DECODE: begin
            opcode_d  = normOpcode(ir[7:4]);
            execIdx_d = 2'd0;
            if (execLen(opcode_d) == 3'd0) begin
              state_d = FETCH_PC;
            end else begin
              state_d  = execState(opcode_d, 2'd0);
              inExec_d = 1'b1;
            end
          end
          default:    state_d = FETCH_PC;
        endcase
      end else begin
        if (({1'b0, execIdx_q} + 3'd1) == execLen(opcode_q)) begin
          state_d  = FETCH_PC;
          inExec_d = 1'b0;
        end else begin
          execIdx_d = execIdx_q + 2'd1;
          state_d   = execState(opcode_q, execIdx_q + 2'd1);
        end
      end
    end
  end

  // Retire on the final return to FETCH_PC or on entry into HALT; leaving
  // HALT is not a new retire.
  always_comb begin
    done_d    = 1'b0;
    retired_d = retired_q;
    if (advance && state_q != HALT &&
        ((state_d == FETCH_PC && !inExec_d) || state_d == HALT)) begin
      done_d    = 1'b1;
      retired_d = retired_q + RETIRE_W'(1);
    end
  end

  assign state      = state_q;
  assign instr_done = done_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed instruction streams for micro_sequencer.
// Stimulus queues the expected per-cycle outputs; a monitor compares them
// one cycle at a time. Define SEQ_STEP_EN to also exercise single-step.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ir = 8'h00;
  logic        resume = 1'b0;
  logic        run = 1'b1;
  logic        step = 1'b0;
  logic [7:0]  state;
  logic        instr_done;
  logic [15:0] retired;

  typedef struct {
    logic [7:0]  st;
    logic        dn;
    logic [15:0] rt;
    string       tag;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  micro_sequencer #(.RETIRE_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ir         (ir),
    .resume     (resume),
`ifdef SEQ_STEP_EN
    .run        (run),
    .step       (step),
`endif
    .state      (state),
    .instr_done (instr_done),
    .retired    (retired)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Compare the DUT outputs against one expected record.
  task automatic checkOutput(input exp_t e);
    checks++;
    if (state !== e.st || instr_done !== e.dn || retired !== e.rt) begin
      errors++;
      $display("[TB] FAIL %s: got state=%02h done=%0b retired=%0d, expected state=%02h done=%0b retired=%0d",
               e.tag, state, instr_done, retired, e.st, e.dn, e.rt);
    end
  endtask

  // Monitor: pops one expectation per cycle, mid-cycle after the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Queue the outputs expected for the coming cycle, then step past it.
  task automatic applyStimulus(input logic [7:0] st, input logic dn,
                               input logic [15:0] rt, input string tag);
    exp_t e;
    e.st  = st;
    e.dn  = dn;
    e.rt  = rt;
    e.tag = tag;
    expQ.push_back(e);
    @(negedge clk);
    #2;
  endtask

  // One whole instruction: codes hold the states after FETCH_PC, LSB first;
  // the last one carries the retire pulse and the new count.
  task automatic runInstr(input logic [7:0] irVal, input logic [63:0] codes,
                          input int n, input logic [15:0] rt, input string tag);
    ir = irVal;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) applyStimulus(codes[8*i +: 8], 1'b1, rt, tag);
      else            applyStimulus(codes[8*i +: 8], 1'b0, rt - 16'd1, tag);
    end
  endtask

  // Directed stimulus sequence.
  initial begin
    exp_t imm;
    applyStimulus(8'h01, 1'b0, 16'd0, "reset0");
    applyStimulus(8'h01, 1'b0, 16'd0, "reset1");
    rst_n = 1'b1;

    runInstr(8'h00, 64'h01_03_02,             3, 16'd1,  "nop");
    runInstr(8'h93, 64'h01_24_23_20_01_03_02, 7, 16'd2,  "call");
    runInstr(8'h1A, 64'h01_11_10_03_02,       5, 16'd3,  "alu");
    runInstr(8'h25, 64'h01_12_03_02,          4, 16'd4,  "mov");
    runInstr(8'h3C, 64'h01_13_01_03_02,       5, 16'd5,  "ldi");

    ir = 8'h40;
    applyStimulus(8'h02, 1'b0, 16'd5, "ld_fi");
    applyStimulus(8'h03, 1'b0, 16'd5, "ld_dec");
    applyStimulus(8'h01, 1'b0, 16'd5, "ld_fpc");
    applyStimulus(8'h14, 1'b0, 16'd5, "ld_addr");
    ir = 8'h10;
    applyStimulus(8'h13, 1'b0, 16'd5, "ld_setreg");
    applyStimulus(8'h01, 1'b1, 16'd6, "ld_done");

    runInstr(8'h50, 64'h01_15_14_01_03_02,    6, 16'd7,  "st");
    runInstr(8'h6F, 64'h01_16_01_03_02,       5, 16'd8,  "jcc");
    runInstr(8'h71, 64'h01_21_20_03_02,       5, 16'd9,  "push");
    runInstr(8'h82, 64'h01_13_20_22_03_02,    6, 16'd10, "pop");
    runInstr(8'hA0, 64'h01_25_20_22_03_02,    6, 16'd11, "ret");

    runInstr(8'hF0, 64'hFF_03_02,             3, 16'd12, "hlt");
    for (int i = 0; i < 10; i++) applyStimulus(8'hFF, 1'b0, 16'd12, "hlt_hold");
    resume = 1'b1;
    ir = 8'hC0;
    applyStimulus(8'h01, 1'b0, 16'd12, "hlt_resume");
    resume = 1'b0;

    runInstr(8'hC0, 64'hFF_03_02,             3, 16'd13, "rsvd_hlt");
    for (int i = 0; i < 3; i++) applyStimulus(8'hFF, 1'b0, 16'd13, "rsvd_hold");
    resume = 1'b1;
    applyStimulus(8'h01, 1'b0, 16'd13, "rsvd_resume");
    runInstr(8'h00, 64'h01_03_02,             3, 16'd14, "nop_resume_ign");
    resume = 1'b0;

    ir = 8'h10;
    applyStimulus(8'h02, 1'b0, 16'd14, "rst_fi");
    applyStimulus(8'h03, 1'b0, 16'd14, "rst_dec");
    applyStimulus(8'h10, 1'b0, 16'd14, "rst_aluexec");
    rst_n = 1'b0;
    #1;
    imm.st = 8'h01; imm.dn = 1'b0; imm.rt = 16'd0; imm.tag = "rst_async";
    checkOutput(imm);
    ir = 8'h00;
    applyStimulus(8'h01, 1'b0, 16'd0, "rst_held");
    rst_n = 1'b1;
    runInstr(8'h00, 64'h01_03_02,             3, 16'd1,  "nop_after_rst");

`ifdef SEQ_STEP_EN
    rst_n = 1'b0;
    run   = 1'b0;
    ir    = 8'h10;
    applyStimulus(8'h01, 1'b0, 16'd0, "ss_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(8'h01, 1'b0, 16'd0, "ss_idle");
    begin
      logic [7:0] seqCodes [4];
      seqCodes[0] = 8'h01; seqCodes[1] = 8'h02;
      seqCodes[2] = 8'h03; seqCodes[3] = 8'h10;
      for (int k = 0; k < 3; k++) begin
        step = 1'b1;
        applyStimulus(seqCodes[k], 1'b0, 16'd0, "ss_sync1");
        step = 1'b0;
        applyStimulus(seqCodes[k], 1'b0, 16'd0, "ss_sync2");
        applyStimulus(seqCodes[k+1], 1'b0, 16'd0, "ss_advance");
        applyStimulus(seqCodes[k+1], 1'b0, 16'd0, "ss_hold1");
        applyStimulus(seqCodes[k+1], 1'b0, 16'd0, "ss_hold2");
      end
    end
    run = 1'b1;
    applyStimulus(8'h11, 1'b0, 16'd0, "ss_run_aluout");
    applyStimulus(8'h01, 1'b1, 16'd1, "ss_run_done");
`endif

    begin
      int budget = 5;
      while (expQ.size() > 0 && budget > 0) begin
        @(negedge clk);
        #2;
        budget--;
      end
      if (expQ.size() > 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
